// File: rtl/cmd_arbiter.sv
// cmd_arbiter: picks one of three command sources (UART, tour, calibration),
// registers its command and runs the cmd_rdy / clr_cmd_rdy / send_resp
// handshake with cmd_proc. The acknowledges go back to the granted source only.
// A watchdog aborts the handshake when cmd_proc stops responding.
module cmd_arbiter #(
  parameter int TMO_W      = 26,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] uart_cmd,
  input  logic        uart_rdy,
  input  logic [15:0] tour_cmd,
  input  logic        tour_rdy,
  input  logic [15:0] cal_cmd,
  input  logic        cal_rdy,
  output logic        uart_clr,
  output logic        tour_clr,
  output logic        cal_clr,
  output logic        uart_done,
  output logic        tour_done,
  output logic        cal_done,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [2:0]  gnt,
  output logic        tmo_err
);

  localparam int SW = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       gnt_reg, gnt_next;
  logic [15:0]      cmd_reg, cmd_next;
  logic [SW-1:0]    starve_reg, starve_next;
  logic [TMO_W-1:0] wdog_reg, wdog_next;

  logic [2:0]  win;
  logic [15:0] win_cmd;
  logic        tmo_hit;
  logic        clr_fire;
  logic        done_fire;

  // Arbitration: cal > tour > uart, unless UART has lost too many times in a row.
  always_comb begin
    win     = 3'b000;
    win_cmd = uart_cmd;
    if (uart_rdy && (starve_reg >= SW'(STARVE_MAX))) begin
      win     = 3'b001;
      win_cmd = uart_cmd;
    end else if (cal_rdy) begin
      win     = 3'b100;
      win_cmd = cal_cmd;
    end else if (tour_rdy) begin
      win     = 3'b010;
      win_cmd = tour_cmd;
    end else if (uart_rdy) begin
      win     = 3'b001;
      win_cmd = uart_cmd;
    end
  end

  // Handshake events; a watchdog abort suppresses any acknowledge in that cycle.
  always_comb begin
    tmo_hit   = (state_reg != IDLE) && (&wdog_reg);
    clr_fire  = (state_reg == ISSUE) && clr_cmd_rdy && !tmo_hit;
    done_fire = !tmo_hit && send_resp &&
                (((state_reg == ISSUE) && clr_cmd_rdy) || (state_reg == WAIT_RESP));
  end

  // Next-state, grant, command, starvation and watchdog logic.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    cmd_next    = cmd_reg;
    starve_next = starve_reg;
    wdog_next   = wdog_reg;
    case (state_reg)
      IDLE: begin
        if (|win) begin
          state_next = ISSUE;
          gnt_next   = win;
          cmd_next   = win_cmd;
          wdog_next  = '0;
          if (win[0]) begin
            starve_next = '0;
          end else if (uart_rdy && !(&starve_reg)) begin
            starve_next = starve_reg + SW'(1);
          end
        end
      end
      ISSUE: begin
        wdog_next = wdog_reg + TMO_W'(1);
        if (tmo_hit || done_fire) begin
          state_next = IDLE;
          gnt_next   = 3'b000;
        end else if (clr_fire) begin
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        wdog_next = wdog_reg + TMO_W'(1);
        if (tmo_hit || done_fire) begin
          state_next = IDLE;
          gnt_next   = 3'b000;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 3'b000;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= 3'b000;
      cmd_reg    <= 16'h0000;
      starve_reg <= '0;
      wdog_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      cmd_reg    <= cmd_next;
      starve_reg <= starve_next;
      wdog_reg   <= wdog_next;
    end
  end

  assign cmd     = cmd_reg;
  assign gnt     = gnt_reg;
  assign cmd_rdy = (state_reg == ISSUE);
  assign tmo_err = tmo_hit;

  assign {cal_clr, tour_clr, uart_clr}    = gnt_reg & {3{clr_fire}};
  assign {cal_done, tour_done, uart_done} = gnt_reg & {3{done_fire}};

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
Arbitrates access to cmd_proc between three command sources: the host UART command stream, the tour move sequencer, and the heading-calibration requester. It grants one source at a time, registers that source's 16-bit command, and runs the cmd_rdy / clr_cmd_rdy / send_resp handshake with cmd_proc. It routes the acknowledges back to the granted source only, and recovers from a stalled cmd_proc with a timeout.

Parameters:
TMO_W, 26, width of the handshake watchdog counter; timeout after 2^TMO_W-1 cycles (about 1.34 s at 50 MHz).
STARVE_MAX, 4, number of consecutive arbitration losses after which UART is forced to win.

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  reset, synchronous, active-low
uart_cmd  in  16  command from UART_wrapper
uart_rdy  in  1  UART command valid; held until uart_clr
tour_cmd  in  16  command from tour sequencer
tour_rdy  in  1  tour command valid; held until tour_clr
cal_cmd  in  16  command from calibration requester
cal_rdy  in  1  calibration command valid; held until cal_clr
uart_clr / tour_clr / cal_clr  out  1 each  clr_cmd_rdy routed to granted source
uart_done / tour_done / cal_done  out  1 each  send_resp routed to granted source
cmd  out  16  registered command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc has taken cmd
send_resp  in  1  cmd_proc finished cmd
gnt  out  3  one-hot grant: bit2=cal, bit1=tour, bit0=uart; 0 when idle
tmo_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous, active-low: on a clk edge with rst_n=0 the block enters IDLE. Reset values: gnt=0, cmd=16'h0000, cmd_rdy=0, all *_clr=0, all *_done=0, tmo_err=0, starvation count=0, watchdog=0.
- Reset is honoured in any state. An in-flight grant is dropped without *_done.
- State machine: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any *_rdy=1, arbitrate in that cycle.
  - Fixed priority is cal > tour > uart.
  - Exception: if uart_rdy=1 and the starvation count is at least STARVE_MAX, uart wins over all.
  - On a grant: latch gnt, register cmd from the winning source, clear the watchdog, go to ISSUE.
  - The command appears at cmd with cmd_rdy=1 one cycle after the arbitration cycle.
- Starvation count (saturating, width clog2(STARVE_MAX)+1):
  - Increments on each grant to a non-UART source while uart_rdy=1.
  - Resets to 0 on a UART grant.
  - Holds otherwise.
- ISSUE:
  - cmd_rdy=1.
  - When clr_cmd_rdy=1, the granted *_clr is driven combinationally that same cycle, and the state goes to WAIT_RESP.
  - If send_resp=1 in the same cycle as clr_cmd_rdy, both the granted *_clr and *_done pulse, and the state goes to IDLE.
- WAIT_RESP:
  - cmd_rdy=0.
  - When send_resp=1, the granted *_done is driven combinationally and the state goes to IDLE.
  - gnt clears on entry to IDLE.
- Spurious inputs: clr_cmd_rdy or send_resp arriving in IDLE are ignored. No *_clr or *_done is asserted.
- Source behaviour after grant: cmd stays constant from grant to return to IDLE, even if the source changes its cmd or drops *_rdy. A dropped *_rdy does not cancel the issued command.
- Back-to-back: at least one IDLE cycle separates grants. The earliest next cmd_rdy is 2 cycles after the send_resp cycle.
- Watchdog:
  - Increments every cycle in ISSUE and WAIT_RESP.
  - On reaching all-ones: tmo_err pulses 1 cycle, state goes to IDLE, gnt clears, cmd_rdy drops, and no *_clr or *_done is issued.
  - The aborted source keeps its *_rdy and rearbitrates normally.
- Only the granted source ever sees *_clr or *_done. At most one bit of gnt is set.

Test Plan:
- Single UART request: uart_cmd=16'h2BF1, uart_rdy=1 in cycle 0. Required: gnt=3'b001, cmd=16'h2BF1, cmd_rdy=1 in cycle 1. clr_cmd_rdy in cycle 3 gives uart_clr that cycle. send_resp in cycle 6 gives uart_done that cycle, and gnt=0 in cycle 7.
- Priority: cal_rdy, tour_rdy, uart_rdy all 1 at once with cal_cmd=16'h0000. Required: first grant is cal (gnt=3'b100, cmd=16'h0000), then tour, then uart. No *_clr or *_done reaches a non-granted source.
- Starvation: tour_rdy and uart_rdy held high with STARVE_MAX=4 and cal idle, each grant completing normally. Required: 4 tour grants, then a uart grant; afterwards tour wins again.
- Source glitch: source changes tour_cmd from 16'h3002 to 16'h37F1 during ISSUE. Required: cmd stays 16'h3002 until IDLE.
- Timeout: TMO_W=4, grant issued, cmd_proc silent. Required: tmo_err pulse 15 cycles after entering ISSUE, cmd_rdy=0 and gnt=0 next cycle, requester rearbitrated.
- Reset and same-cycle handshake:
  - rst_n=0 for 1 cycle during WAIT_RESP: all outputs 0 next cycle, no *_done.
  - clr_cmd_rdy and send_resp both 1 in ISSUE: *_clr and *_done pulse together, then IDLE.
